// File: rtl/uart_frame_rx.sv
// uart_frame_rx
// Receive side of the framed UART link. The serial line is oversampled at
// FREQ_COEF system clocks per bit, characters are deserialised LSB first,
// and the opt/len/payload message is reassembled into one parallel word.
//
// Ports:
//   CLK        system clock
//   RST        synchronous, active-high reset
//   in_bit     asynchronous serial line, idle high
//   full_data  reassembled message {opt, len, payload}, held until next message
//   out_valid  one-cycle pulse, full_data has just been updated
//   err        one-cycle pulse, message aborted
//   err_code   abort reason (1 framing, 2 length, 3 timeout), held until next err
module uart_frame_rx #(
    parameter int FULL_DATA_SIZE = 40,
    parameter int BYTE_SIZE      = 8,
    parameter int FREQ_COEF      = 4,
    parameter int TIMEOUT_BITS   = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_bit,
    output logic [FULL_DATA_SIZE-1:0] full_data,
    output logic                      out_valid,
    output logic                      err,
    output logic [1:0]                err_code
);

    localparam int NBYTES     = FULL_DATA_SIZE / BYTE_SIZE;
    localparam int PAY_W      = (NBYTES - 2) * BYTE_SIZE;
    localparam int BAUD_W     = $clog2(FREQ_COEF);
    localparam int BIT_W      = $clog2(BYTE_SIZE);
    localparam int IDLE_LIMIT = TIMEOUT_BITS * FREQ_COEF;
    localparam int IDLE_W     = $clog2(IDLE_LIMIT);

    localparam logic [BAUD_W-1:0]    HALF_LAST = BAUD_W'(FREQ_COEF / 2 - 1);
    localparam logic [BAUD_W-1:0]    FULL_LAST = BAUD_W'(FREQ_COEF - 1);
    localparam logic [BIT_W-1:0]     BIT_LAST  = BIT_W'(BYTE_SIZE - 1);
    localparam logic [BYTE_SIZE-1:0] MAX_PAY   = BYTE_SIZE'(NBYTES - 2);
    localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);

    localparam logic [1:0] ERR_FRAME   = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {C_IDLE, C_START, C_DATA, C_STOP} c_state_t;
    typedef enum logic [1:0] {M_OPT, M_LEN, M_PAY} m_state_t;

    logic [1:0]                sync_r;
    logic                      line_s;

    c_state_t                  c_state_r, c_state_n;
    logic [BAUD_W-1:0]         baud_r, baud_n;
    logic [BIT_W-1:0]          bit_r, bit_n;
    logic [BYTE_SIZE-1:0]      byte_r, byte_n;
    logic                      start_det_s;
    logic                      byte_acc_s;
    logic                      frame_err_s;

    m_state_t                  m_state_r, m_state_n;
    logic [FULL_DATA_SIZE-1:0] stage_r, stage_n;
    logic [BYTE_SIZE-1:0]      pay_cnt_r, pay_cnt_n;
    logic [IDLE_W-1:0]         idle_cnt_r, idle_cnt_n;
    logic                      done_s;
    logic                      err_det_s;
    logic [1:0]                err_code_s;

    assign line_s = sync_r[1];

    // Two-flop synchroniser for the asynchronous serial input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], in_bit};
        end
    end

    // Character FSM state and bit-timing registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            c_state_r <= C_IDLE;
            baud_r    <= '0;
            bit_r     <= '0;
            byte_r    <= '0;
        end else begin
            c_state_r <= c_state_n;
            baud_r    <= baud_n;
            bit_r     <= bit_n;
            byte_r    <= byte_n;
        end
    end

    // Character FSM: start qualification at mid-bit, data sampling, stop check.
    always_comb begin
        c_state_n   = c_state_r;
        baud_n      = baud_r;
        bit_n       = bit_r;
        byte_n      = byte_r;
        start_det_s = 1'b0;
        byte_acc_s  = 1'b0;
        frame_err_s = 1'b0;
        case (c_state_r)
            C_IDLE: begin
                if (!line_s) begin
                    start_det_s = 1'b1;
                    c_state_n   = C_START;
                    baud_n      = '0;
                    bit_n       = '0;
                end else begin
                    c_state_n = C_IDLE;
                end
            end
            C_START: begin
                if (baud_r == HALF_LAST) begin
                    baud_n = '0;
                    // A start bit that is gone by mid-bit was only a glitch.
                    if (line_s) begin
                        c_state_n = C_IDLE;
                    end else begin
                        c_state_n = C_DATA;
                    end
                end else begin
                    baud_n = baud_r + BAUD_W'(1);
                end
            end
            C_DATA: begin
                if (baud_r == FULL_LAST) begin
                    baud_n = '0;
                    byte_n = {line_s, byte_r[BYTE_SIZE-1:1]};
                    if (bit_r == BIT_LAST) begin
                        c_state_n = C_STOP;
                    end else begin
                        bit_n = bit_r + BIT_W'(1);
                    end
                end else begin
                    baud_n = baud_r + BAUD_W'(1);
                end
            end
            C_STOP: begin
                if (baud_r == FULL_LAST) begin
                    baud_n = '0;
                    // Returning to idle mid stop bit lets a back-to-back start edge be seen.
                    c_state_n = C_IDLE;
                    if (line_s) begin
                        byte_acc_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end else begin
                    baud_n = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                c_state_n = C_IDLE;
            end
        endcase
    end

    // Message FSM state, staging word, payload and idle counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            m_state_r  <= M_OPT;
            stage_r    <= '0;
            pay_cnt_r  <= '0;
            idle_cnt_r <= '0;
        end else begin
            m_state_r  <= m_state_n;
            stage_r    <= stage_n;
            pay_cnt_r  <= pay_cnt_n;
            idle_cnt_r <= idle_cnt_n;
        end
    end

    // Message FSM: opt/len/payload assembly, length check and inter-byte timeout.
    always_comb begin
        m_state_n  = m_state_r;
        stage_n    = stage_r;
        pay_cnt_n  = pay_cnt_r;
        idle_cnt_n = idle_cnt_r;
        done_s     = 1'b0;
        err_det_s  = 1'b0;
        err_code_s = 2'd0;
        if (frame_err_s) begin
            err_det_s  = 1'b1;
            err_code_s = ERR_FRAME;
            m_state_n  = M_OPT;
            idle_cnt_n = '0;
        end else if (byte_acc_s) begin
            idle_cnt_n = '0;
            case (m_state_r)
                M_OPT: begin
                    // Clearing here guarantees no stale payload from a longer message.
                    stage_n = '0;
                    stage_n[FULL_DATA_SIZE-1 -: BYTE_SIZE] = byte_r;
                    m_state_n = M_LEN;
                end
                M_LEN: begin
                    stage_n[FULL_DATA_SIZE-BYTE_SIZE-1 -: BYTE_SIZE] = byte_r;
                    if (byte_r > MAX_PAY) begin
                        err_det_s  = 1'b1;
                        err_code_s = ERR_LEN;
                        m_state_n  = M_OPT;
                    end else if (byte_r == '0) begin
                        done_s    = 1'b1;
                        m_state_n = M_OPT;
                    end else begin
                        pay_cnt_n = byte_r;
                        m_state_n = M_PAY;
                    end
                end
                M_PAY: begin
                    // Shift keeps the payload low-justified, first byte most significant.
                    stage_n[PAY_W-1:0]     = stage_r[PAY_W-1:0] << BYTE_SIZE;
                    stage_n[BYTE_SIZE-1:0] = byte_r;
                    pay_cnt_n = pay_cnt_r - BYTE_SIZE'(1);
                    if (pay_cnt_r == BYTE_SIZE'(1)) begin
                        done_s    = 1'b1;
                        m_state_n = M_OPT;
                    end else begin
                        m_state_n = M_PAY;
                    end
                end
                default: begin
                    m_state_n = M_OPT;
                end
            endcase
        end else if (m_state_r == M_OPT) begin
            idle_cnt_n = '0;
        end else if (c_state_r == C_IDLE) begin
            if (start_det_s) begin
                idle_cnt_n = '0;
            end else if (idle_cnt_r == IDLE_LAST) begin
                err_det_s  = 1'b1;
                err_code_s = ERR_TIMEOUT;
                m_state_n  = M_OPT;
                idle_cnt_n = '0;
            end else begin
                idle_cnt_n = idle_cnt_r + IDLE_W'(1);
            end
        end else begin
            idle_cnt_n = idle_cnt_r;
        end
    end

    // Registered outputs: completion and abort pulses, held word and reason.
    always_ff @(posedge CLK) begin
        if (RST) begin
            full_data <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            out_valid <= done_s;
            err       <= err_det_s;
            if (done_s) begin
                full_data <= stage_n;
            end
            if (err_det_s) begin
                err_code <= err_code_s;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Testbench for uart_frame_rx: directed and random messages driven as serial
// frames, checked against a message-level reference model.
module tb_uart_frame_rx;

    localparam int F = 4;

    logic        CLK;
    logic        RST;
    logic        in_bit;
    logic [39:0] full_data;
    logic        out_valid;
    logic        err;
    logic [1:0]  err_code;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int n_both   = 0;

    uart_frame_rx #(
        .FULL_DATA_SIZE(40),
        .BYTE_SIZE(8),
        .FREQ_COEF(F),
        .TIMEOUT_BITS(16)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .in_bit(in_bit),
        .full_data(full_data),
        .out_valid(out_valid),
        .err(err),
        .err_code(err_code)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulse counters sampled on the falling edge.
    always @(negedge CLK) begin
        if (!RST) begin
            if (out_valid) n_valid <= n_valid + 1;
            if (err) n_err <= n_err + 1;
            if (out_valid && err) n_both <= n_both + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: outcome of a complete byte sequence at message level.
    // kind 1 = valid word, kind 2 = length error, kind 0 = incomplete.
    function automatic void model_msg(input logic [7:0] q[$], output int kind,
                                      output logic [39:0] data, output logic [1:0] code);
        int len;
        kind = 0;
        data = 40'h0;
        code = 2'd0;
        if (q.size() < 2) return;
        len = int'(q[1]);
        if (len > 3) begin
            kind = 2;
            code = 2'd2;
            return;
        end
        if (q.size() < 2 + len) return;
        data = {q[0], q[1], 24'h0};
        for (int i = 0; i < len; i++) begin
            data = data | (40'(q[2+i]) << (8 * (len - 1 - i)));
        end
        kind = 1;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        in_bit = 1'b0;
        repeat (F) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            in_bit = b[i];
            repeat (F) @(negedge CLK);
        end
        in_bit = stop_v;
        repeat (F) @(negedge CLK);
    endtask

    // Exact-latency check: pulse appears one cycle after the last stop sample.
    task automatic run_exact(input string tag, input logic [7:0] q[$]);
        int kind;
        logic [39:0] exp_d;
        logic [1:0] exp_c;
        int e0;
        model_msg(q, kind, exp_d, exp_c);
        e0 = n_err;
        foreach (q[i]) send_byte(q[i], 1'b1);
        chk({tag, "_valid_before"}, 64'(out_valid), 64'd0);
        @(negedge CLK);
        chk({tag, "_valid_pulse"}, 64'(out_valid), 64'd1);
        chk({tag, "_data"}, 64'(full_data), 64'(exp_d));
        @(negedge CLK);
        chk({tag, "_valid_single"}, 64'(out_valid), 64'd0);
        chk({tag, "_data_hold"}, 64'(full_data), 64'(exp_d));
        chk({tag, "_no_err"}, 64'(n_err - e0), 64'd0);
    endtask

    task automatic run_msg(input string tag, input logic [7:0] q[$]);
        int kind;
        logic [39:0] exp_d;
        logic [1:0] exp_c;
        logic [39:0] prev;
        int v0;
        int e0;
        model_msg(q, kind, exp_d, exp_c);
        v0 = n_valid;
        e0 = n_err;
        prev = full_data;
        foreach (q[i]) send_byte(q[i], 1'b1);
        repeat (4) @(negedge CLK);
        if (kind == 1) begin
            chk({tag, "_valid_cnt"}, 64'(n_valid - v0), 64'd1);
            chk({tag, "_data"}, 64'(full_data), 64'(exp_d));
            chk({tag, "_err_cnt"}, 64'(n_err - e0), 64'd0);
        end else begin
            chk({tag, "_valid_cnt"}, 64'(n_valid - v0), 64'd0);
            chk({tag, "_err_cnt"}, 64'(n_err - e0), 64'd1);
            chk({tag, "_err_code"}, 64'(err_code), 64'(exp_c));
            chk({tag, "_data_kept"}, 64'(full_data), 64'(prev));
        end
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [39:0] prev;
        int          v0;
        int          e0;
        int          waited;
        int          len;

        in_bit = 1'b1;
        RST    = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset_full_data", 64'(full_data), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        chk("reset_err_code", 64'(err_code), 64'd0);
        RST = 1'b0;
        repeat (4) @(negedge CLK);

        // Full-length message, back to back.
        q = {8'h00, 8'h03, 8'hAA, 8'hBB, 8'h47};
        run_exact("full_msg", q);
        chk("full_msg_const", 64'(full_data), 64'h00_03_AA_BB_47);

        // Zero-length message.
        q = {8'h01, 8'h00};
        run_exact("zero_len", q);
        chk("zero_len_const", 64'(full_data), 64'h01_00_00_00_00);

        // Shorter message after a longer one leaves no stale payload.
        q = {8'h00, 8'h02, 8'hAA, 8'hBB};
        run_msg("two_pay", q);
        q = {8'h00, 8'h01, 8'h47};
        run_msg("one_pay", q);
        chk("no_stale_const", 64'(full_data), 64'h00_01_00_00_47);

        // Length error then a clean empty message.
        q = {8'h00, 8'h05};
        run_msg("len_err", q);
        q = {8'h00, 8'h00};
        run_msg("after_len_err", q);

        q = {8'h5A, 8'h02, 8'h13, 8'hC4};
        run_msg("pre_frame", q);

        // Framing error on the third byte.
        prev = full_data;
        v0 = n_valid;
        e0 = n_err;
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hAA, 1'b0);
        chk("frame_err_before", 64'(err), 64'd0);
        @(negedge CLK);
        chk("frame_err_pulse", 64'(err), 64'd1);
        chk("frame_err_code", 64'(err_code), 64'd1);
        in_bit = 1'b1;
        @(negedge CLK);
        chk("frame_err_single", 64'(err), 64'd0);
        repeat (60) @(negedge CLK);
        chk("frame_no_valid", 64'(n_valid - v0), 64'd0);
        chk("frame_err_cnt", 64'(n_err - e0), 64'd1);
        chk("frame_data_kept", 64'(full_data), 64'(prev));

        // Timeout while waiting for the second payload byte.
        prev = full_data;
        v0 = n_valid;
        e0 = n_err;
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'hAA, 1'b1);
        waited = 0;
        while (err !== 1'b1 && waited < 100) begin
            @(negedge CLK);
            waited++;
        end
        chk("timeout_window", 64'(waited >= 60 && waited <= 70), 64'd1);
        chk("timeout_code", 64'(err_code), 64'd3);
        repeat (5) @(negedge CLK);
        chk("timeout_no_valid", 64'(n_valid - v0), 64'd0);
        chk("timeout_err_cnt", 64'(n_err - e0), 64'd1);
        chk("timeout_data_kept", 64'(full_data), 64'(prev));

        // One-cycle glitch on the idle line.
        v0 = n_valid;
        e0 = n_err;
        in_bit = 1'b0;
        @(negedge CLK);
        in_bit = 1'b1;
        repeat (60) @(negedge CLK);
        chk("glitch_no_valid", 64'(n_valid - v0), 64'd0);
        chk("glitch_no_err", 64'(n_err - e0), 64'd0);
        q = {8'h77, 8'h02, 8'h12, 8'h34};
        run_msg("after_glitch", q);

        // Reset in the middle of a payload byte.
        v0 = n_valid;
        e0 = n_err;
        send_byte(8'h00, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'hAA, 1'b1);
        in_bit = 1'b0;
        repeat (F) @(negedge CLK);
        in_bit = 1'b1;
        repeat (3 * F) @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("midrst_full_data", 64'(full_data), 64'd0);
        chk("midrst_err_code", 64'(err_code), 64'd0);
        RST = 1'b0;
        repeat (100) @(negedge CLK);
        chk("midrst_no_valid", 64'(n_valid - v0), 64'd0);
        chk("midrst_no_err", 64'(n_err - e0), 64'd0);
        q = {8'h3C, 8'h03, 8'h01, 8'h02, 8'h03};
        run_msg("after_rst", q);

        // Random messages, including some with an illegal length.
        for (int k = 0; k < 8; k++) begin
            len = int'($urandom_range(0, 5));
            q = {};
            q.push_back(8'($urandom));
            q.push_back(8'(len));
            if (len <= 3) begin
                for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            end
            run_msg("rand", q);
        end

        repeat (2) @(negedge CLK);
        chk("no_valid_err_overlap", 64'(n_both), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
